// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
//   N-channel arbiter feeding one registered output stage. Each cycle one valid
//   channel is granted, either round-robin (starting after the last channel
//   served) or by fixed priority (lowest index wins). The granted word and a
//   one-hot tag are captured together in the output register, which is
//   flow-controlled by out_ready.
//
// Parameters
//   N_INPUTS   : number of input channels (1..32)
//   W_INPUT    : data width per channel (1..256)
//   FIXED_PRIO : 0 = round-robin, 1 = fixed priority
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : channel i word at [i*W_INPUT +: W_INPUT]
//   in_valid   : per-channel valid
//   in_ready   : per-channel accept strobe, at most one bit set
//   out_data   : registered selected word
//   out_sel    : registered one-hot tag of the sourcing channel
//   out_valid  : out_data/out_sel are valid
//   out_ready  : downstream accepts the output word this cycle
// -----------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int N_INPUTS   = 4,
    parameter int W_INPUT    = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_INPUTS*W_INPUT-1:0]   in_data,
    input  logic [N_INPUTS-1:0]           in_valid,
    output logic [N_INPUTS-1:0]           in_ready,
    output logic [W_INPUT-1:0]            out_data,
    output logic [N_INPUTS-1:0]           out_sel,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic [W_INPUT-1:0]  out_data_q,  out_data_d;
    logic [N_INPUTS-1:0] out_sel_q,   out_sel_d;
    logic                out_valid_q, out_valid_d;
    // One-hot pointer to the channel of the most recent transfer.
    logic [N_INPUTS-1:0] last_q,      last_d;

    logic                load_en;
    logic [N_INPUTS-1:0] above_last;
    logic [N_INPUTS-1:0] req_hi;
    logic [N_INPUTS-1:0] grant;
    logic [W_INPUT-1:0]  sel_word;

    // Isolates the lowest set bit: x & -x, written in unsigned form.
    function automatic logic [N_INPUTS-1:0] lowest_one(input logic [N_INPUTS-1:0] x);
        return x & (~x + N_INPUTS'(1));
    endfunction

    // The stage can take a word when empty or draining this cycle. rst_n is
    // folded in so nothing is acknowledged upstream while reset is held.
    assign load_en = rst_n & (~out_valid_q | out_ready);

    // Mask of channel positions strictly above the last-served channel.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop, so no path leaves it unassigned and no latch is inferred.
        logic seen;
        above_last = '0;
        seen       = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            above_last[i] = seen;
            seen          = seen | last_q[i];
        end
    end

    // Round-robin: prefer the lowest valid channel above last; if none,
    // wrap around to the lowest valid channel overall.
    always_comb begin
        req_hi = in_valid & above_last;
        grant  = lowest_one(in_valid);
        if (FIXED_PRIO == 0 && (|req_hi)) begin
            grant = lowest_one(req_hi);
        end
    end

    assign in_ready = grant & {N_INPUTS{load_en}};

    // AND-OR select: grant is one-hot, so at most one term contributes.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            sel_word = sel_word | (in_data[i*W_INPUT +: W_INPUT] & {W_INPUT{grant[i]}});
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (load_en) begin
            if (|grant) begin
                out_data_d  = sel_word;
                out_sel_d   = grant;
                out_valid_d = 1'b1;
                last_d      = grant;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            // Pointing at the top channel makes channel 0 first after reset.
            last_q      <= N_INPUTS'(1) << (N_INPUTS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
//   Drives a round-robin instance and a fixed-priority instance of rr_arb_mux
//   (N_INPUTS=4, W_INPUT=8) from shared inputs and compares both against a
//   cycle-level reference model based on channel-index arithmetic.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic           out_ready;

    logic [N-1:0]   rr_in_ready, fx_in_ready;
    logic [W-1:0]   rr_out_data, fx_out_data;
    logic [N-1:0]   rr_out_sel,  fx_out_sel;
    logic           rr_out_valid, fx_out_valid;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = round-robin DUT, 1 = fixed DUT.
    bit           m_valid [2];
    logic [W-1:0] m_data  [2];
    logic [N-1:0] m_sel   [2];
    int           m_last  [2];

    rr_arb_mux #(.N_INPUTS(N), .W_INPUT(W), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_valid(rr_out_valid), .out_ready(out_ready)
    );

    rr_arb_mux #(.N_INPUTS(N), .W_INPUT(W), .FIXED_PRIO(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fx_in_ready), .out_data(fx_out_data), .out_sel(fx_out_sel),
        .out_valid(fx_out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Channel chosen by the arbitration rules, or -1 when none is valid.
    function automatic int ref_pick(logic [N-1:0] v, int last, bit fixed);
        if (v == '0) return -1;
        if (fixed) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(int m);
        int g;
        bit ld;
        ld = !m_valid[m] || out_ready;
        g  = ref_pick(in_valid, m_last[m], m == 1);
        if (ld && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = '0;
            m_last[m]  = N - 1;
        end
    endtask

    // Advances the model with the current inputs, then crosses the edge.
    task automatic tick();
        for (int m = 0; m < 2; m++) begin
            int g;
            bit ld;
            ld = !m_valid[m] || out_ready;
            g  = ref_pick(in_valid, m_last[m], m == 1);
            if (ld) begin
                if (g >= 0) begin
                    m_data[m]  = in_data[g*W +: W];
                    m_sel[m]   = 4'b0001 << g;
                    m_valid[m] = 1'b1;
                    m_last[m]  = g;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = $urandom;
        model_reset();
        @(posedge clk);
        #1;
        total++; if (rr_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rr_out_valid); end
        total++; if (rr_out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rr_out_data); end
        total++; if (rr_out_sel !== 4'b0000) begin bad++; $display("FAIL reset_sel: got %b want 0000", rr_out_sel); end
        total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready_rr: got %b want 0000", rr_in_ready); end
        total++; if (fx_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready_fx: got %b want 0000", fx_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rr_all();
        logic [N-1:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [N-1:0] er;
            #1;
            er = exp_ready(0);
            total++; if (rr_in_ready !== er) begin bad++; $display("FAIL rr_all_in_ready c=%0d: got %b want %b", c, rr_in_ready, er); end
            tick();
            total++; if (rr_out_sel !== exp_seq[c]) begin bad++; $display("FAIL rr_all_sel c=%0d: got %b want %b", c, rr_out_sel, exp_seq[c]); end
            total++; if (rr_out_data !== m_data[0]) begin bad++; $display("FAIL rr_all_data c=%0d: got %h want %h", c, rr_out_data, m_data[0]); end
            total++; if (rr_out_valid !== 1'b1) begin bad++; $display("FAIL rr_all_valid c=%0d: got %b want 1", c, rr_out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        in_data   = {8'h33, 8'h00, 8'h11, 8'h00};
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            logic [W-1:0] want;
            want = (c % 2 == 0) ? 8'h11 : 8'h33;
            tick();
            total++; if (rr_out_data !== want) begin bad++; $display("FAIL alternate_data c=%0d: got %h want %h", c, rr_out_data, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data   = {8'h33, 8'h00, 8'h11, 8'h00};
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        tick();
        total++; if (rr_out_data !== 8'h11) begin bad++; $display("FAIL bp_first_data: got %h want 11", rr_out_data); end
        @(negedge clk);
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready c=%0d: got %b want 0000", c, rr_in_ready); end
            tick();
            total++; if (rr_out_data !== 8'h11 || rr_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold c=%0d: got %h/%b want 11/1", c, rr_out_data, rr_out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (rr_in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready: got %b want 1000", rr_in_ready); end
        tick();
        total++; if (rr_out_data !== 8'h33 || rr_out_sel !== 4'b1000) begin bad++; $display("FAIL bp_release_data: got %h/%b want 33/1000", rr_out_data, rr_out_sel); end
        @(negedge clk);
    endtask

    task automatic test_fixed();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            logic [W-1:0] ch0;
            in_data = $urandom;
            ch0     = in_data[W-1:0];
            #1;
            total++; if (fx_in_ready !== 4'b0001) begin bad++; $display("FAIL fixed_in_ready c=%0d: got %b want 0001", c, fx_in_ready); end
            tick();
            total++; if (fx_out_sel !== 4'b0001 || fx_out_data !== ch0) begin bad++; $display("FAIL fixed_out c=%0d: got %b/%h want 0001/%h", c, fx_out_sel, fx_out_data, ch0); end
            @(negedge clk);
        end
    endtask

    task automatic test_bubble();
        do_reset();
        in_data   = {8'h00, 8'h5A, 8'h00, 8'h00};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        tick();
        total++; if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h5A) begin bad++; $display("FAIL bubble_first: got %b/%h want 1/5a", rr_out_valid, rr_out_data); end
        @(negedge clk);
        in_valid = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            in_data = $urandom;
            #1;
            total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL bubble_in_ready c=%0d: got %b want 0000", c, rr_in_ready); end
            tick();
            total++; if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h5A) begin bad++; $display("FAIL bubble_idle c=%0d: got %b/%h want 0/5a", c, rr_out_valid, rr_out_data); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_data   = {8'h00, 8'h00, 8'h00, 8'h77};
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        total++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 4'b0001) begin bad++; $display("FAIL areset_pre: got %b/%b want 1/0001", rr_out_valid, rr_out_sel); end
        #2;
        in_valid = 4'b1000;
        rst_n    = 1'b0;
        model_reset();
        #1;
        total++; if (rr_out_valid !== 1'b0 || rr_out_sel !== 4'b0000) begin bad++; $display("FAIL areset_immediate: got %b/%b want 0/0000", rr_out_valid, rr_out_sel); end
        total++; if (rr_in_ready !== 4'b0000) begin bad++; $display("FAIL areset_in_ready: got %b want 0000", rr_in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (rr_in_ready !== 4'b1000) begin bad++; $display("FAIL areset_release_ready: got %b want 1000", rr_in_ready); end
        tick();
        total++; if (rr_out_sel !== 4'b1000) begin bad++; $display("FAIL areset_first_sel: got %b want 1000", rr_out_sel); end
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] er0, er1;
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er0 = exp_ready(0);
            er1 = exp_ready(1);
            total++; if (rr_in_ready !== er0) begin bad++; $display("FAIL rand_rr_in_ready c=%0d: got %b want %b", c, rr_in_ready, er0); end
            total++; if (fx_in_ready !== er1) begin bad++; $display("FAIL rand_fx_in_ready c=%0d: got %b want %b", c, fx_in_ready, er1); end
            tick();
            total++; if (rr_out_valid !== m_valid[0] || rr_out_sel !== m_sel[0] || rr_out_data !== m_data[0]) begin
                bad++; $display("FAIL rand_rr_out c=%0d: got %b/%b/%h want %b/%b/%h", c, rr_out_valid, rr_out_sel, rr_out_data, m_valid[0], m_sel[0], m_data[0]);
            end
            total++; if (fx_out_valid !== m_valid[1] || fx_out_sel !== m_sel[1] || fx_out_data !== m_data[1]) begin
                bad++; $display("FAIL rand_fx_out c=%0d: got %b/%b/%h want %b/%b/%h", c, fx_out_valid, fx_out_sel, fx_out_data, m_valid[1], m_sel[1], m_data[1]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        test_reset();
        test_rr_all();
        test_alternate();
        test_backpressure();
        test_fixed();
        test_bubble();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N_INPUTS, default 4: number of input channels; legal range 1..32.
REQ-002 Parameter W_INPUT, default 32: data width per channel; legal range 1..256.
REQ-003 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 selects fixed priority (lowest index wins).
REQ-004 One clock and one reset; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  N_INPUTS*W_INPUT  channel i data at bits [i*W_INPUT +: W_INPUT].
REQ-008 in_valid  input  N_INPUTS  channel i holds a valid word.
REQ-009 in_ready  output  N_INPUTS  channel i word is accepted this cycle; at most one bit set.
REQ-010 out_data  output  W_INPUT  registered selected word.
REQ-011 out_sel  output  N_INPUTS  registered one-hot tag of the channel that sourced out_data.
REQ-012 out_valid  output  1  out_data/out_sel are valid.
REQ-013 out_ready  input  1  downstream accepts the output word this cycle.

Function
REQ-014 The block SHALL hold one output register stage (data, sel, valid) and SHALL define load_en = !out_valid || out_ready.
REQ-015 The block SHALL compute a one-hot grant combinationally from in_valid and SHALL set grant to all-zero when in_valid is all-zero.
REQ-016 Round-robin mode: grant SHALL go to the first valid channel at or above index (last+1) mod N_INPUTS, searching upward with wrap-around; last is the index of the most recent transfer.
REQ-017 Fixed mode: grant SHALL go to the lowest-index valid channel; the last pointer SHALL still update but SHALL NOT affect selection.
REQ-018 in_ready SHALL equal grant & {N_INPUTS{load_en}}; in_ready SHALL NOT depend combinationally on in_data.
REQ-019 The selected word SHALL be formed as an AND-OR mux of in_data using grant, with no index decode.
REQ-020 When load_en and grant is non-zero, on the clock edge out_data SHALL load the selected word, out_sel SHALL load grant, out_valid SHALL become 1, and last SHALL load grant.
REQ-021 When load_en and grant is zero, out_valid SHALL become 0, and out_data, out_sel and last SHALL hold.
REQ-022 When !load_en (out_valid=1, out_ready=0), out_data, out_sel, out_valid and last SHALL hold and in_ready SHALL be all-zero.
REQ-023 Latency from input transfer to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 word/cycle with out_ready held at 1.
REQ-024 A channel that deasserts in_valid before it is granted SHALL lose no state; the arbiter SHALL be memoryless apart from last.
REQ-025 With N_INPUTS=1, grant SHALL equal in_valid[0] and the last pointer MAY be constant.
REQ-026 Round-robin fairness: with all N_INPUTS channels continuously valid and out_ready=1, each channel SHALL be granted exactly once in every N_INPUTS consecutive transfers.

Reset
REQ-027 On rst_n low, out_valid SHALL be 0, out_data SHALL be 0, out_sel SHALL be 0, and last SHALL point at index N_INPUTS-1, so channel 0 has top priority after reset.
REQ-028 Reset assertion mid-transfer SHALL discard the output word, and in_ready SHALL be 0 while rst_n is low.
REQ-029 After rst_n deasserts, the first grant SHALL follow REQ-016/REQ-017 from the reset pointer.

Verification (N_INPUTS=4, W_INPUT=8, FIXED_PRIO=0 unless stated)
REQ-030 Reset release, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0001,0010,0100,1000,0001; out_data matches the sourcing channel each cycle; out_valid stays 1.
REQ-031 in_valid=4'b1010 continuously, data ch1=0x11, ch3=0x33, out_ready=1 -> out_data alternates 0x11,0x33, starting with 0x11.
REQ-032 Backpressure: out_valid=1 with out_data=0x11, out_ready=0 for 3 cycles, ch3 valid -> in_ready=0, out_data held at 0x11; first cycle out_ready=1 -> in_ready[3]=1 and next out_data=0x33.
REQ-033 FIXED_PRIO=1, in_valid=4'b1111, out_ready=1 -> out_sel=0001 on every cycle; channel 3 is never granted.
REQ-034 Bubble: single transfer from ch2 (0x5A), then in_valid=0 with out_ready=1 -> out_valid is 1 for one cycle then 0; out_data stays 0x5A.
REQ-035 rst_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0, out_sel=0 immediately (asynchronous); after release with in_valid=4'b1000, first out_sel=1000.
